// File: rtl/mul_share_arbiter_pkg.sv
// Shared types and constants for the multiplier-sharing arbiter.
// State encoding, default sizing and result width used by every file in the slice.
package mul_share_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam int DEF_NREQ = 4;
  localparam int DEF_LAT  = 2;
  localparam int RES_W    = 64;

endpackage

// File: rtl/mul_share_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request at or after ptr,
// wrapping modulo NREQ.
module rr_pick
  import mul_share_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   winner,
  output logic [NREQ-1:0] onehot
);

  logic [IW-1:0] w_idx;

  // Walk offsets from farthest to nearest so the requester closest to ptr wins.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    w_idx  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = IW'((int'(ptr) + k) % NREQ);
      if (req[w_idx]) begin
        valid  = 1'b1;
        winner = w_idx;
      end
    end
    onehot = valid ? (NREQ'(1) << winner) : '0;
  end

endmodule

// File: rtl/multiplier_async.sv
// Shared 32x32 unsigned combinational multiplier; the full 64-bit product settles
// within the arbiter's LAT cycles.
module multiplier_async (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] p
);

  assign p = {32'b0, a} * {32'b0, b};

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one 32x32 multiplier among NREQ requesters, with one
// operation in flight at a time.
module mul_share_arbiter
  import mul_share_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int LAT  = DEF_LAT,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*32-1:0] op_a,
  input  logic [NREQ*32-1:0] op_b,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [RES_W-1:0]  result,
  output logic [IW-1:0]     owner,
  output logic              busy
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  state_t           r_state;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_owner;
  logic [CW-1:0]    r_cnt;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [NREQ-1:0]  r_gnt;
  logic [NREQ-1:0]  r_done;
  logic [RES_W-1:0] r_result;

  logic             w_valid;
  logic [IW-1:0]    w_winner;
  logic [NREQ-1:0]  w_onehot;
  logic [63:0]      w_prod;
  logic [31:0]      w_a_arr [NREQ];
  logic [31:0]      w_b_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_a_arr[gi] = op_a[gi*32 +: 32];
    assign w_b_arr[gi] = op_b[gi*32 +: 32];
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req),
    .ptr    (r_ptr),
    .valid  (w_valid),
    .winner (w_winner),
    .onehot (w_onehot)
  );

  multiplier_async u_mul (
    .a (r_a),
    .b (r_b),
    .p (w_prod)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_owner  <= '0;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_result <= '0;
    end else begin
      r_gnt  <= '0;
      r_done <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_gnt   <= w_onehot;
            r_owner <= w_winner;
            r_a     <= w_a_arr[w_winner];
            r_b     <= w_b_arr[w_winner];
            r_cnt   <= CW'(LAT - 1);
            r_ptr   <= (w_winner == IW'(NREQ - 1)) ? '0 : w_winner + 1'b1;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // The product has settled once the countdown reaches zero.
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_result <= w_prod;
            r_done   <= NREQ'(1) << r_owner;
            r_state  <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign gnt    = r_gnt;
  assign done   = r_done;
  assign result = r_result;
  assign owner  = r_owner;
  assign busy   = (r_state == ST_BUSY);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed plus randomized bench for mul_share_arbiter, checked against a
// transaction-level model of round-robin arbitration and the unsigned product.
module tb_mul_share_arbiter;

  localparam int NREQ = 4;
  localparam int LAT  = 2;
  localparam int IW   = $clog2(NREQ);

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ*32-1:0] op_a;
  logic [NREQ*32-1:0] op_b;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [63:0]        result;
  logic [IW-1:0]      owner;
  logic               busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_gnt_cyc = -1;
  int m_ptr   = 0;
  int last_w  = 0;
  logic [63:0] m_result = '0;

  mul_share_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .op_a   (op_a),
    .op_b   (op_b),
    .gnt    (gnt),
    .done   (done),
    .result (result),
    .owner  (owner),
    .busy   (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: first requester at or after the pointer, wrapping.
  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    op_a[i*32 +: 32] = a;
    op_b[i*32 +: 32] = b;
  endtask

  // One complete transaction starting from IDLE with at least one req set.
  task automatic do_op(input bit chk_spacing, input bit mutate, input logic [31:0] mut_val);
    int w;
    logic [63:0] exp_p;
    w = pick(req, m_ptr);
    if (w < 0) begin
      check("no_request_in_do_op", 64'(req), 64'(1));
      return;
    end
    exp_p = {32'b0, op_a[w*32 +: 32]} * {32'b0, op_b[w*32 +: 32]};
    tick();
    check("gnt", 64'(gnt), 64'(1) << w);
    check("owner", 64'(owner), 64'(w));
    check("busy_at_gnt", 64'(busy), 64'(1));
    check("done_at_gnt", 64'(done), 64'(0));
    if (chk_spacing && last_gnt_cyc >= 0)
      check("grant_spacing", 64'(cyc - last_gnt_cyc), 64'(LAT + 1));
    last_gnt_cyc = cyc;
    req[w] = 1'b0;
    if (mutate) op_a[w*32 +: 32] = mut_val;
    for (int i = 1; i < LAT; i++) begin
      tick();
      check("gnt_drop", 64'(gnt), 64'(0));
      check("done_early", 64'(done), 64'(0));
      check("busy_mid", 64'(busy), 64'(1));
    end
    tick();
    check("done", 64'(done), 64'(1) << w);
    check("result", result, exp_p);
    check("busy_at_done", 64'(busy), 64'(0));
    check("gnt_at_done", 64'(gnt), 64'(0));
    m_ptr    = (w + 1) % NREQ;
    m_result = exp_p;
    last_w   = w;
  endtask

  initial begin
    rst  = 1'b0;
    req  = '1;
    op_a = '0;
    op_b = '0;

    // Reset held with all requests active.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_gnt", 64'(gnt), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_result", result, 64'(0));
      check("rst_owner", 64'(owner), 64'(0));
    end
    set_ops(0, 32'd11, 32'd13);
    rst = 1'b1;
    do_op(1'b0, 1'b0, 32'h0);
    check("first_owner_zero", 64'(last_w), 64'(0));
    req = '0;

    // Single op on requester 2, then result must hold.
    set_ops(2, 32'd7, 32'd6);
    req = 4'b0100;
    do_op(1'b0, 1'b0, 32'h0);
    check("result_42", result, 64'd42);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("result_hold", result, m_result);
      check("idle_done", 64'(done), 64'(0));
      check("idle_busy", 64'(busy), 64'(0));
    end

    // Full-width product and multiply-by-zero.
    set_ops(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    req = 4'b0001;
    do_op(1'b0, 1'b0, 32'h0);
    check("result_max", result, 64'hFFFF_FFFE_0000_0001);
    set_ops(1, 32'h1234_5678, 32'h0);
    req = 4'b0010;
    do_op(1'b0, 1'b0, 32'h0);
    check("result_zero", result, 64'h0);

    // Operand change after grant must not affect the in-flight op.
    set_ops(1, 32'd3, 32'd5);
    req = 4'b0010;
    do_op(1'b0, 1'b1, 32'd9);
    check("operand_stable", result, 64'd15);

    // Reset one cycle after grant aborts silently.
    req = 4'b0100;
    set_ops(2, 32'd100, 32'd100);
    tick();
    check("pre_abort_gnt", 64'(gnt), 64'b0100);
    rst = 1'b0;
    req = '0;
    tick();
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_result", result, 64'(0));
    tick();
    check("abort_no_late_done", 64'(done), 64'(0));
    m_ptr    = 0;
    m_result = '0;
    rst = 1'b1;
    req = 4'b1000;
    set_ops(3, 32'd21, 32'd2);
    do_op(1'b0, 1'b0, 32'h0);
    check("post_abort_owner", 64'(last_w), 64'(3));

    // Round-robin with all requesters active: order 0,1,2,3,0 at LAT+1 spacing.
    for (int i = 0; i < NREQ; i++) set_ops(i, 32'(i + 2), 32'(i + 10));
    req = '1;
    last_gnt_cyc = -1;
    for (int n = 0; n < 5; n++) begin
      do_op(1'b1, 1'b0, 32'h0);
      check("rr_order", 64'(last_w), 64'(n % NREQ));
      req[last_w] = 1'b1;
    end
    req = '0;
    tick();

    // Randomized traffic; pending requests carry over between ops.
    for (int n = 0; n < 24; n++) begin
      req = req | NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) set_ops(i, rnd32(), rnd32());
      do_op(1'b0, 1'b0, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
